trace_req_queue: RTL and testbench
==================================

# trace_req_queue

Downstream stage of the trace parser in the DRAM memory-controller model. Accepts parsed trace requests (time, core, operation, address) one per handshake and buffers them in a 16-entry in-order queue. Releases each request to the DRAM scheduler once the CPU-cycle counter reaches the request's trace time, with the physical address already decoded into DDR5 fields.

## Interface
- DEPTH, 16: queue entries; power of two, at least 2.
- TIME_W, 64: width of trace time and cycle counter.
- ADDR_W, 34: physical address width.
- clk  in  1  single clock; one tick is one CPU cycle.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  parser has a request.
- in_ready  out  1  queue can accept; equals !full.
- in_time  in  TIME_W  trace CPU cycle of the request.
- in_core  in  4  requesting core id.
- in_op  in  2  0 read, 1 write, 2 ifetch, 3 illegal.
- in_addr  in  ADDR_W  physical address.
- out_valid  out  1  head entry is due.
- out_ready  in  1  scheduler consumes the head.
- out_time, out_core, out_op  out  TIME_W/4/2  head fields.
- out_row  out  16  addr[33:18].
- out_col  out  10  {addr[17:12], addr[5:2]}.
- out_bank  out  2  addr[11:10].
- out_bg  out  3  addr[9:7].
- out_chan  out  1  addr[6].
- count  out  $clog2(DEPTH)+1  occupancy.
- cycle  out  TIME_W  current CPU cycle.
- err_illegal  out  1  one-cycle pulse when an op-3 request is dropped.

## Operation
- Push: in_valid && in_ready. op 0–2 writes the entry at wr_ptr and increments wr_ptr and count. op 3 is accepted and discarded, pulses err_illegal next cycle, and leaves count unchanged.
- Due: queue non-empty and head.time <= cycle. out_valid = due.
- Pop: out_valid && out_ready. Increments rd_ptr and decrements count.
- Pointers wrap modulo DEPTH. Full = (count == DEPTH). Empty = (count == 0).
- Strict FIFO order. A later entry with a smaller time still waits behind the head.
- Head state machine, two states:
  - WAIT (non-empty, not due) → READY when head.time <= cycle.
  - READY → WAIT after a pop if the new head is not due.
  - An empty queue is WAIT with out_valid = 0.
- Byte select addr[1:0] is ignored.
- Out fields are combinational from the head register. They are don't-care when out_valid = 0 but must be stable while out_valid && !out_ready.

## Timing
- Reset values: count, rd_ptr, wr_ptr, cycle = 0; out_valid = 0; err_illegal = 0; in_ready = 1. Entry contents are not reset.
- cycle increments every clk and wraps at 2^TIME_W.
- Push-to-out_valid latency: 1 cycle minimum. An entry written at edge N can be valid after edge N if its time <= cycle.
- Push and pop in the same cycle: both occur and count is unchanged. When full, in_ready = 0, so no push occurs.
- Push into an empty queue with a pop in the same cycle: the pop does not apply, because out_valid was 0.
- in_ready depends only on registered count, with no combinational path from out_ready.
- Reset asserted mid-operation: the queue is emptied immediately and all queued requests are lost.

## Configuration
- TRACE_REQ_LOG_EN defined: each accepted push and each pop prints cycle, core, op, and hex address via $display. Each illegal drop prints a warning.
- Undefined: no display statements and identical cycle behaviour.

## Structure
- Package trace_req_pkg holds:
  - enum op_e (READ, WRITE, IFETCH, ILLEGAL)
  - address field bit positions and widths
  - packed struct req_t (time, core, op, addr)
  - packed struct dram_addr_t (row, col, bank, bg, chan)
- One sub-module, trace_addr_map, a combinational ADDR_W → dram_addr_t decode, instantiated on the head entry.

## Test plan
- Reset, then push time=5 op=0 addr=0x3_FFFF_FFFC → out_valid rises when cycle=5. row=0xFFFF, col=0x3FF, bank=3, bg=7, chan=1.
- Push time=0 at cycle 10 → out_valid one cycle after the push. Hold out_ready=0 for 3 cycles → fields stable, count=1.
- Push 16 entries without popping → in_ready=0 and count=16. A 17th in_valid is not accepted. One pop → in_ready=1 on the next cycle.
- Push times 100, 50 → nothing released before cycle 100. Both are released in order at or after cycle 100.
- Push op=3 → err_illegal pulses for 1 cycle, count stays 0, out_valid stays 0.
- Assert rst_n low with 4 entries queued → count=0, out_valid=0, cycle=0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/trace_req_pkg.sv
// Shared types for the trace request queue: operation codes, request record and
// the DDR5 address-field layout used by the head-entry decoder.
package trace_req_pkg;

    localparam int REQ_TIME_W = 64;
    localparam int REQ_ADDR_W = 34;
    localparam int CORE_W     = 4;

    // DDR5 field placement inside the physical address; addr[1:0] is the byte select.
    localparam int ROW_LSB   = 18;
    localparam int ROW_W     = 16;
    localparam int COLH_LSB  = 12;
    localparam int COLH_W    = 6;
    localparam int COLL_LSB  = 2;
    localparam int COLL_W    = 4;
    localparam int COL_W     = COLH_W + COLL_W;
    localparam int BANK_LSB  = 10;
    localparam int BANK_W    = 2;
    localparam int BG_LSB    = 7;
    localparam int BG_W      = 3;
    localparam int CHAN_LSB  = 6;

    typedef enum logic [1:0] {
        READ    = 2'd0,
        WRITE   = 2'd1,
        IFETCH  = 2'd2,
        ILLEGAL = 2'd3
    } op_e;

    typedef struct packed {
        logic [REQ_TIME_W-1:0] req_time;
        logic [CORE_W-1:0]     core;
        op_e                   op;
        logic [REQ_ADDR_W-1:0] addr;
    } req_t;

    typedef struct packed {
        logic [ROW_W-1:0]  row;
        logic [COL_W-1:0]  col;
        logic [BANK_W-1:0] bank;
        logic [BG_W-1:0]   bg;
        logic              chan;
    } dram_addr_t;

endpackage

// File: rtl/trace_addr_map.sv
// Combinational physical-address to DDR5 field decode (row/col/bank/bg/chan).
module trace_addr_map
    import trace_req_pkg::*;
#(
    parameter int ADDR_W = REQ_ADDR_W
) (
    input  logic [ADDR_W-1:0] addr_i,
    output dram_addr_t        dram_o
);

    logic unused_byte_sel;

    assign dram_o.row  = addr_i[ROW_LSB +: ROW_W];
    assign dram_o.col  = {addr_i[COLH_LSB +: COLH_W], addr_i[COLL_LSB +: COLL_W]};
    assign dram_o.bank = addr_i[BANK_LSB +: BANK_W];
    assign dram_o.bg   = addr_i[BG_LSB +: BG_W];
    assign dram_o.chan = addr_i[CHAN_LSB];

    // Byte select never reaches the DRAM; fold it away explicitly.
    assign unused_byte_sel = ^addr_i[1:0];

endmodule

// File: rtl/trace_req_queue.sv
// In-order trace request queue: buffers parsed requests and releases the head once
// the CPU-cycle counter reaches its trace time. Optional logging: TRACE_REQ_LOG_EN.
module trace_req_queue
    import trace_req_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int TIME_W = REQ_TIME_W,
    parameter int ADDR_W = REQ_ADDR_W,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [TIME_W-1:0] in_time,
    input  logic [3:0]        in_core,
    input  logic [1:0]        in_op,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [TIME_W-1:0] out_time,
    output logic [3:0]        out_core,
    output logic [1:0]        out_op,
    output logic [15:0]       out_row,
    output logic [9:0]        out_col,
    output logic [1:0]        out_bank,
    output logic [2:0]        out_bg,
    output logic              out_chan,
    output logic [CNT_W-1:0]  count,
    output logic [TIME_W-1:0] cycle,
    output logic              err_illegal
);

    typedef enum logic {
        WAIT  = 1'b0,
        READY = 1'b1
    } head_state_e;

    head_state_e      state_q, state_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [TIME_W-1:0] cycle_q;
    logic             err_q;

    req_t       mem_q [DEPTH];
    req_t       head;
    req_t       wr_req;
    dram_addr_t head_dram;

    logic full, empty, push, push_keep, push_drop, pop, head_due;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign in_ready  = !full;
    assign push      = in_valid && in_ready;
    assign push_keep = push && (op_e'(in_op) != ILLEGAL);
    assign push_drop = push && (op_e'(in_op) == ILLEGAL);

    assign head     = mem_q[rd_ptr_q];
    assign head_due = !empty && (head.req_time <= cycle_q);

    // READY keeps a released head valid regardless of the counter; a fresh head is judged live.
    assign out_valid = !empty && ((state_q == READY) || head_due);
    assign pop       = out_valid && out_ready;

    assign wr_req = '{req_time: in_time, core: in_core, op: op_e'(in_op), addr: in_addr};

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d = state_q;
        unique case (state_q)
            WAIT:    if (head_due && !pop) state_d = READY;
            READY:   if (pop) state_d = WAIT;
            default: state_d = WAIT;
        endcase
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(push_keep);
        count_d  = count_q;
        unique case ({push_keep, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= WAIT;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            cycle_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            cycle_q  <= cycle_q + TIME_W'(1);
            err_q    <= push_drop;
        end
    end

    // NOTE: entry storage is deliberately not reset; count gates every read, so stale contents are never seen.
    always_ff @(posedge clk) begin
        if (push_keep) begin
            mem_q[wr_ptr_q] <= wr_req;
        end
    end

    trace_addr_map #(
        .ADDR_W (ADDR_W)
    ) u_addr_map (
        .addr_i (head.addr),
        .dram_o (head_dram)
    );

    assign out_time    = head.req_time;
    assign out_core    = head.core;
    assign out_op      = head.op;
    assign out_row     = head_dram.row;
    assign out_col     = head_dram.col;
    assign out_bank    = head_dram.bank;
    assign out_bg      = head_dram.bg;
    assign out_chan    = head_dram.chan;
    assign count       = count_q;
    assign cycle       = cycle_q;
    assign err_illegal = err_q;

`ifdef TRACE_REQ_LOG_EN
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (push_keep) begin
                $display("[trace_req_queue] push cycle=%0d core=%0d op=%0d addr=0x%0h",
                         cycle_q, in_core, in_op, in_addr);
            end
            if (push_drop) begin
                $display("[trace_req_queue] warning: illegal op dropped cycle=%0d core=%0d addr=0x%0h",
                         cycle_q, in_core, in_addr);
            end
            if (pop) begin
                $display("[trace_req_queue] pop  cycle=%0d core=%0d op=%0d addr=0x%0h",
                         cycle_q, head.core, head.op, head.addr);
            end
        end
    end
`endif

endmodule

// File: tb/tb_trace_req_queue.sv
// Directed bench for trace_req_queue: release timing, stall stability, full/backpressure,
// FIFO ordering behind a late head, illegal-op drop and asynchronous reset.
module tb_trace_req_queue;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_time;
    logic [3:0]  in_core;
    logic [1:0]  in_op;
    logic [33:0] in_addr;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_time;
    logic [3:0]  out_core;
    logic [1:0]  out_op;
    logic [15:0] out_row;
    logic [9:0]  out_col;
    logic [1:0]  out_bank;
    logic [2:0]  out_bg;
    logic        out_chan;
    logic [4:0]  count;
    logic [63:0] cycle;
    logic        err_illegal;

    int tests_run    = 0;
    int tests_failed = 0;

    trace_req_queue dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_time     (in_time),
        .in_core     (in_core),
        .in_op       (in_op),
        .in_addr     (in_addr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_time    (out_time),
        .out_core    (out_core),
        .out_op      (out_op),
        .out_row     (out_row),
        .out_col     (out_col),
        .out_bank    (out_bank),
        .out_bg      (out_bg),
        .out_chan    (out_chan),
        .count       (count),
        .cycle       (cycle),
        .err_illegal (err_illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [63:0] t, input logic [3:0] c, input logic [1:0] op,
                         input logic [33:0] a);
        in_valid = 1'b1;
        in_time  = t;
        in_core  = c;
        in_op    = op;
        in_addr  = a;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_time   = '0;
        in_core   = '0;
        in_op     = '0;
        in_addr   = '0;
        out_ready = 1'b0;
        #12;
        rst_n = 1'b1;

        // Reset state
        check("rst_count", count, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_cycle", cycle, 0);
        check("rst_err", err_illegal, 0);

        // Time-5 read with all-ones fields
        drive(64'd5, 4'd3, 2'd0, 34'h3_FFFF_FFFC);
        tick();
        in_valid = 1'b0;
        check("t1_count", count, 1);
        check("t1_not_due", out_valid, 0);
        for (int i = 0; i < 20 && !out_valid; i++) tick();
        check("t1_timeout", out_valid, 1);
        check("t1_release_cycle", cycle, 5);
        check("t1_time", out_time, 5);
        check("t1_core", out_core, 3);
        check("t1_op", out_op, 0);
        check("t1_row", out_row, 16'hFFFF);
        check("t1_col", out_col, 10'h3FF);
        check("t1_bank", out_bank, 3);
        check("t1_bg", out_bg, 7);
        check("t1_chan", out_chan, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t1_popped_count", count, 0);
        check("t1_popped_valid", out_valid, 0);

        // Already-due entry pushed at cycle 10, then held by backpressure
        for (int i = 0; i < 50 && cycle != 64'd10; i++) tick();
        check("t2_at_cycle10", cycle, 10);
        drive(64'd0, 4'd9, 2'd1, 34'h0_ABCD_1E48);
        tick();
        in_valid = 1'b0;
        check("t2_valid_next", out_valid, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_hold_valid", out_valid, 1);
            check("t2_hold_count", count, 1);
            check("t2_hold_core", out_core, 9);
            check("t2_hold_op", out_op, 1);
            check("t2_hold_row", out_row, 16'h2AF3);
            check("t2_hold_col", out_col, 10'h112);
            check("t2_hold_bank", out_bank, 3);
            check("t2_hold_bg", out_bg, 4);
            check("t2_hold_chan", out_chan, 1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t2_popped_count", count, 0);

        // Fill to 16, refuse a 17th, then drain in order
        for (int i = 0; i < 16; i++) begin
            drive(64'd0, 4'(i), 2'd2, 34'(i) << 2);
            tick();
        end
        in_valid = 1'b0;
        check("t3_full_count", count, 16);
        check("t3_full_ready", in_ready, 0);
        drive(64'd0, 4'd15, 2'd0, 34'h1_0000_0000);
        tick();
        in_valid = 1'b0;
        check("t3_17th_count", count, 16);
        check("t3_head_core", out_core, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t3_ready_after_pop", in_ready, 1);
        check("t3_count_after_pop", count, 15);
        for (int i = 1; i < 16; i++) begin
            check("t3_order_core", out_core, 64'(i));
            check("t3_order_valid", out_valid, 1);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        check("t3_drained", count, 0);
        check("t3_drained_valid", out_valid, 0);

        // Late head (100) blocks an earlier-time entry (50)
        drive(64'd100, 4'd1, 2'd0, 34'h0);
        tick();
        drive(64'd50, 4'd2, 2'd1, 34'h4);
        tick();
        in_valid = 1'b0;
        check("t4_before_100", (cycle < 64'd100), 1);
        check("t4_count", count, 2);
        for (int i = 0; i < 200 && !out_valid; i++) tick();
        check("t4_timeout", out_valid, 1);
        check("t4_release_cycle", cycle, 100);
        check("t4_first_time", out_time, 100);
        check("t4_first_core", out_core, 1);
        out_ready = 1'b1;
        tick();
        check("t4_second_valid", out_valid, 1);
        check("t4_second_time", out_time, 50);
        check("t4_second_core", out_core, 2);
        tick();
        out_ready = 1'b0;
        check("t4_empty", count, 0);

        // Illegal op is accepted and dropped with a single-cycle error pulse
        drive(64'd0, 4'd7, 2'd3, 34'h123);
        tick();
        in_valid = 1'b0;
        check("t5_err_pulse", err_illegal, 1);
        check("t5_count", count, 0);
        check("t5_valid", out_valid, 0);
        tick();
        check("t5_err_clear", err_illegal, 0);
        check("t5_valid_after", out_valid, 0);

        // Asynchronous reset with four entries queued
        for (int i = 0; i < 4; i++) begin
            drive(64'hFFFF_0000, 4'(i), 2'd0, 34'(i) << 2);
            tick();
        end
        in_valid = 1'b0;
        check("t6_count_before", count, 4);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_count", count, 0);
        check("t6_async_valid", out_valid, 0);
        check("t6_async_cycle", cycle, 0);
        check("t6_async_ready", in_ready, 1);
        #10;
        rst_n = 1'b1;
        tick();
        check("t6_after_count", count, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
